// File: rtl/sprite_line_fetch.sv
// Per-line sprite fetch: scans the sprite table during blanking and retains the first MAX_HITS
// sprites that cover the coming line. A registered lookup then reports which sprite covers each pixel.
//   state | meaning
//   IDLE  | waiting for line_start; retained entries drive the pixel lookup
//   SCAN  | issuing table addresses 0..SLOTS-1; evaluating the previous word
//   DRAIN | evaluating the word for the final address
module sprite_line_fetch #(
    parameter int SLOTS    = 8,
    parameter int MAX_HITS = 4,
    parameter int SPR_SIZE = 32
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        line_start,
    input  logic [9:0]  line_y,
    input  logic        video_on,
    input  logic [9:0]  pixel_x,
    output logic [2:0]  rd_addr,
    input  logic [31:0] rd_data,
    output logic        pix_hit,
    output logic [3:0]  pix_id,
    output logic [2:0]  pix_row,
    output logic [2:0]  pix_col,
    output logic [4:0]  pix_u,
    output logic [4:0]  pix_v,
    output logic        busy,
    output logic        overflow
);

    localparam int          CNT_W     = $clog2(MAX_HITS + 1);
    localparam logic [2:0]  LAST_ADDR = 3'(SLOTS - 1);

    typedef enum logic [1:0] {IDLE, SCAN, DRAIN} state_t;

    typedef struct packed {
        logic       valid;
        logic [3:0] id;
        logic       hflip;
        logic [9:0] x;
        logic [2:0] row;
        logic [2:0] col;
        logic [4:0] v;
    } entry_t;

    state_t             state;
    logic [9:0]         line_lat;
    logic               pend;
    logic [CNT_W-1:0]   hit_cnt;
    entry_t             ent [MAX_HITS];

    logic [10:0]        word_y;
    logic [10:0]        line_ext;
    logic               word_hit;
    entry_t             new_ent;

    // Word on rd_data belongs to the address issued in the previous cycle.
    assign word_y   = {1'b0, rd_data[15:6]};
    assign line_ext = {1'b0, line_lat};
    assign word_hit = rd_data[31] && (line_ext >= word_y) &&
                      (line_ext < word_y + 11'(SPR_SIZE));

    always_comb begin
        new_ent       = '0;
        new_ent.valid = 1'b1;
        new_ent.id    = rd_data[30:27];
        new_ent.hflip = rd_data[26];
        new_ent.x     = rd_data[25:16];
        new_ent.row   = rd_data[5:3];
        new_ent.col   = rd_data[2:0];
        new_ent.v     = line_lat[4:0] - rd_data[10:6];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            busy     <= 1'b0;
            rd_addr  <= '0;
            pend     <= 1'b0;
            overflow <= 1'b0;
            hit_cnt  <= '0;
            line_lat <= '0;
            for (int i = 0; i < MAX_HITS; i++) ent[i] <= '0;
        end else if (line_start) begin
            state    <= SCAN;
            busy     <= 1'b1;
            rd_addr  <= '0;
            pend     <= 1'b0;
            overflow <= 1'b0;
            hit_cnt  <= '0;
            line_lat <= line_y;
            for (int i = 0; i < MAX_HITS; i++) ent[i] <= '0;
        end else begin
            if (pend && word_hit) begin
                if (hit_cnt < CNT_W'(MAX_HITS)) begin
                    for (int i = 0; i < MAX_HITS; i++)
                        if (hit_cnt == CNT_W'(i)) ent[i] <= new_ent;
                    hit_cnt <= hit_cnt + 1'b1;
                end else begin
                    overflow <= 1'b1;
                end
            end
            case (state)
                IDLE: begin
                    pend <= 1'b0;
                end
                SCAN: begin
                    pend <= 1'b1;
                    if (rd_addr == LAST_ADDR) state <= DRAIN;
                    else                      rd_addr <= rd_addr + 1'b1;
                end
                DRAIN: begin
                    pend    <= 1'b0;
                    busy    <= 1'b0;
                    rd_addr <= '0;
                    state   <= IDLE;
                end
                default: begin
                    pend  <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

    logic [10:0] px_ext;
    logic        sel_hit;
    logic [3:0]  sel_id;
    logic [2:0]  sel_row;
    logic [2:0]  sel_col;
    logic [4:0]  sel_u;
    logic [4:0]  sel_v;

    assign px_ext = {1'b0, pixel_x};

    // Walk from the highest index down so the lowest matching entry wins.
    always_comb begin
        sel_hit = 1'b0;
        sel_id  = '0;
        sel_row = '0;
        sel_col = '0;
        sel_u   = '0;
        sel_v   = '0;
        for (int i = MAX_HITS - 1; i >= 0; i--) begin
            if (ent[i].valid && ({1'b0, ent[i].x} <= px_ext) &&
                (px_ext < {1'b0, ent[i].x} + 11'(SPR_SIZE))) begin
                sel_hit = 1'b1;
                sel_id  = ent[i].id;
                sel_row = ent[i].row;
                sel_col = ent[i].col;
                sel_v   = ent[i].v;
                sel_u   = ent[i].hflip ?
                          5'(SPR_SIZE - 1) - (pixel_x[4:0] - ent[i].x[4:0]) :
                          (pixel_x[4:0] - ent[i].x[4:0]);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset || !(video_on && !busy && sel_hit)) begin
            pix_hit <= 1'b0;
            pix_id  <= '0;
            pix_row <= '0;
            pix_col <= '0;
            pix_u   <= '0;
            pix_v   <= '0;
        end else begin
            pix_hit <= 1'b1;
            pix_id  <= sel_id;
            pix_row <= sel_row;
            pix_col <= sel_col;
            pix_u   <= sel_u;
            pix_v   <= sel_v;
        end
    end

endmodule

// File: tb/tb_sprite_line_fetch.sv
// Bench for sprite_line_fetch: a synchronous sprite-table model, directed line fetches, and a
// scoreboard monitor that checks every pixel lookup one cycle after it is issued.
module tb_sprite_line_fetch;

    logic        clk;
    logic        reset;
    logic        line_start;
    logic [9:0]  line_y;
    logic        video_on;
    logic [9:0]  pixel_x;
    logic [2:0]  rd_addr;
    logic [31:0] rd_data;
    logic        pix_hit;
    logic [3:0]  pix_id;
    logic [2:0]  pix_row;
    logic [2:0]  pix_col;
    logic [4:0]  pix_u;
    logic [4:0]  pix_v;
    logic        busy;
    logic        overflow;

    sprite_line_fetch dut (
        .clk(clk), .reset(reset), .line_start(line_start), .line_y(line_y),
        .video_on(video_on), .pixel_x(pixel_x), .rd_addr(rd_addr), .rd_data(rd_data),
        .pix_hit(pix_hit), .pix_id(pix_id), .pix_row(pix_row), .pix_col(pix_col),
        .pix_u(pix_u), .pix_v(pix_v), .busy(busy), .overflow(overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [31:0] mem [8];
    always @(posedge clk) rd_data <= mem[rd_addr];

    typedef struct {
        logic       hit;
        logic [3:0] id;
        logic [2:0] row;
        logic [2:0] col;
        logic [4:0] u;
        logic [4:0] v;
        string      name;
    } exp_t;

    exp_t q[$];
    int   tests = 0;
    int   fails = 0;
    logic probe = 1'b0;

    function automatic logic [31:0] desc(logic vld, logic [3:0] id, logic hf, logic [9:0] x,
                                         logic [9:0] y, logic [2:0] row, logic [2:0] col);
        return {vld, id, hf, x, y, row, col};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic clear_mem();
        for (int i = 0; i < 8; i++) mem[i] = '0;
    endtask

    task automatic start_line(logic [9:0] y);
        line_start = 1'b1;
        line_y     = y;
        tick();
        line_start = 1'b0;
    endtask

    task automatic wait_idle(output int n);
        n = 0;
        while (busy && n < 50) begin
            n++;
            tick();
        end
    endtask

    task automatic run_line(logic [9:0] y, string name);
        int n;
        start_line(y);
        wait_idle(n);
        chk(name, 32'(n), 32'd9);
    endtask

    task automatic look(logic [9:0] px, logic von, logic h, logic [3:0] id, logic [2:0] row,
                        logic [2:0] col, logic [4:0] u, logic [4:0] v, string name);
        exp_t e;
        e.hit = h; e.id = id; e.row = row; e.col = col; e.u = u; e.v = v; e.name = name;
        q.push_back(e);
        pixel_x  = px;
        video_on = von;
        probe    = 1'b1;
        tick();
        probe    = 1'b0;
        video_on = 1'b0;
    endtask

    task automatic miss(logic [9:0] px, string name);
        look(px, 1'b1, 1'b0, 4'd0, 3'd0, 3'd0, 5'd0, 5'd0, name);
    endtask

    // Monitor: a lookup issued before an edge is visible just after it.
    initial begin
        logic samp;
        exp_t e;
        forever begin
            @(posedge clk);
            samp = probe;
            #2;
            if (samp) begin
                tests++;
                if (q.size() == 0) begin
                    fails++;
                    $display("FAIL scoreboard_empty: unexpected lookup result hit=%0b", pix_hit);
                end else begin
                    e = q.pop_front();
                    if ({pix_hit, pix_id, pix_row, pix_col, pix_u, pix_v} !==
                        {e.hit, e.id, e.row, e.col, e.u, e.v}) begin
                        fails++;
                        $display("FAIL %s: got hit=%0b id=%0d row=%0d col=%0d u=%0d v=%0d expected hit=%0b id=%0d row=%0d col=%0d u=%0d v=%0d",
                                 e.name, pix_hit, pix_id, pix_row, pix_col, pix_u, pix_v,
                                 e.hit, e.id, e.row, e.col, e.u, e.v);
                    end
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL timeout: bench did not finish");
        $fatal(1);
    end

    initial begin
        int n;
        reset = 1'b1; line_start = 1'b0; line_y = '0; video_on = 1'b0; pixel_x = '0;
        clear_mem();
        tick(); tick();
        chk("reset_busy", 32'(busy), 0);
        chk("reset_overflow", 32'(overflow), 0);
        chk("reset_rd_addr", 32'(rd_addr), 0);
        chk("reset_pix", {20'd0, pix_hit, pix_id, pix_row, pix_col, pix_u, pix_v}, 0);
        reset = 1'b0;
        tick();

        // Single sprite at (80,400)
        mem[0] = desc(1, 4'd0, 0, 10'd80, 10'd400, 3'd0, 3'd2);
        run_line(10'd410, "basic_busy_cycles");
        chk("basic_overflow", 32'(overflow), 0);
        look(10'd85, 1, 1, 4'd0, 3'd0, 3'd2, 5'd5, 5'd10, "basic_hit_85");
        look(10'd85, 0, 0, 4'd0, 3'd0, 3'd0, 5'd0, 5'd0, "basic_video_off");
        miss(10'd79, "basic_left_edge");
        look(10'd111, 1, 1, 4'd0, 3'd0, 3'd2, 5'd31, 5'd10, "basic_right_edge");
        miss(10'd112, "basic_past_right");

        run_line(10'd432, "below_busy");
        miss(10'd80, "below_80");
        miss(10'd85, "below_85");
        miss(10'd111, "below_111");
        run_line(10'd399, "above_busy");
        miss(10'd80, "above_80");
        miss(10'd100, "above_100");
        run_line(10'd431, "last_row_busy");
        look(10'd80, 1, 1, 4'd0, 3'd0, 3'd2, 5'd0, 5'd31, "last_row_hit");

        // Six sprites on one line: only the first four are retained
        clear_mem();
        for (int i = 0; i < 6; i++)
            mem[i] = desc(1, 4'(i + 3), 0, 10'(10 * i), 10'd100, 3'(i), 3'(7 - i));
        run_line(10'd100, "crowd_busy");
        chk("crowd_overflow", 32'(overflow), 1);
        look(10'd15, 1, 1, 4'd3, 3'd0, 3'd7, 5'd15, 5'd0, "crowd_priority");
        look(10'd45, 1, 1, 4'd5, 3'd2, 3'd5, 5'd25, 5'd0, "crowd_slot2");
        look(10'd60, 1, 1, 4'd6, 3'd3, 3'd4, 5'd30, 5'd0, "crowd_slot3");
        miss(10'd65, "crowd_dropped");
        mem[4] = '0; mem[5] = '0;
        run_line(10'd100, "four_busy");
        chk("four_no_overflow", 32'(overflow), 0);

        // Horizontally flipped sprite
        clear_mem();
        mem[2] = desc(1, 4'd9, 1, 10'd200, 10'd50, 3'd5, 3'd6);
        run_line(10'd60, "flip_busy");
        look(10'd200, 1, 1, 4'd9, 3'd5, 3'd6, 5'd31, 5'd10, "flip_left");
        look(10'd231, 1, 1, 4'd9, 3'd5, 3'd6, 5'd0, 5'd10, "flip_right");
        miss(10'd232, "flip_past");
        miss(10'd199, "flip_before");

        // Restart on line_start at cycle 4 of a fetch
        clear_mem();
        mem[0] = desc(1, 4'd1, 0, 10'd100, 10'd0, 3'd1, 3'd1);
        mem[1] = desc(1, 4'd2, 0, 10'd100, 10'd200, 3'd2, 3'd2);
        start_line(10'd10);
        tick(); tick(); tick();
        start_line(10'd210);
        wait_idle(n);
        chk("restart_busy", 32'(n), 32'd9);
        look(10'd110, 1, 1, 4'd2, 3'd2, 3'd2, 5'd10, 5'd10, "restart_new_line");

        // Reset mid-scan after overflow has been raised
        clear_mem();
        for (int i = 0; i < 6; i++)
            mem[i] = desc(1, 4'(i + 3), 0, 10'(10 * i), 10'd100, 3'(i), 3'(7 - i));
        run_line(10'd100, "pre_reset_busy");
        start_line(10'd100);
        for (int i = 0; i < 6; i++) tick();
        chk("midscan_overflow_set", 32'(overflow), 1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("midreset_busy", 32'(busy), 0);
        chk("midreset_overflow", 32'(overflow), 0);
        chk("midreset_pix_hit", 32'(pix_hit), 0);
        miss(10'd15, "midreset_lookup");
        run_line(10'd100, "post_reset_busy");
        look(10'd15, 1, 1, 4'd3, 3'd0, 3'd7, 5'd15, 5'd0, "post_reset_hit");

        // Reset wins over a simultaneous line_start
        reset = 1'b1; line_start = 1'b1; line_y = 10'd100;
        tick();
        reset = 1'b0; line_start = 1'b0;
        chk("reset_vs_start_busy", 32'(busy), 0);
        tick();
        chk("reset_vs_start_idle", 32'(busy), 0);
        miss(10'd15, "reset_vs_start_lookup");

        tick(); tick();
        chk("scoreboard_drained", 32'(q.size()), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/sprite_line_fetch.md
SPRITE_LINE_FETCH -- requirements
Module: sprite_line_fetch

Interface
REQ-001 SHALL have parameter SLOTS, default 8, meaning number of sprite-table words scanned per line (addresses 0..SLOTS-1).
REQ-002 SHALL have parameter MAX_HITS, default 4, meaning sprites retained per line.
REQ-003 SHALL have parameter SPR_SIZE, default 32, meaning sprite width/height in pixels (power of two).
REQ-004 SHALL have port clk, input, 1, system clock.
REQ-005 SHALL have port reset, input, 1; reset is synchronous, active-high, clock clk.
REQ-006 SHALL have port line_start, input, 1, one-cycle pulse at start of horizontal blanking preceding line line_y.
REQ-007 SHALL have port line_y, input, 10, screen line about to be displayed.
REQ-008 SHALL have port video_on, input, 1, active-pixel qualifier.
REQ-009 SHALL have port pixel_x, input, 10, current pixel column.
REQ-010 SHALL have port rd_addr, output, 3, sprite-table read address.
REQ-011 SHALL have port rd_data, input, 32, sprite-table word, valid one cycle after rd_addr.
REQ-012 SHALL have port pix_hit, output, 1, pixel covered by a retained sprite.
REQ-013 SHALL have ports pix_id (4), pix_row (3), pix_col (3), pix_u (5), pix_v (5), outputs, sprite-ROM selector and texel coordinates.
REQ-014 SHALL have ports busy (1) and overflow (1), outputs, fetch in progress / more than MAX_HITS sprites on line.

Function
REQ-015 Descriptor word SHALL decode as: [31] valid, [30:27] id, [26] hflip, [25:16] x, [15:6] y, [5:3] row, [2:0] col.
REQ-016 FSM SHALL have states IDLE, SCAN, DRAIN; reset and power-up state IDLE.
REQ-017 IDLE: on line_start SHALL latch line_y, invalidate all hit entries, clear overflow, set rd_addr=0, enter SCAN.
REQ-018 SCAN: SHALL increment rd_addr each cycle; after issuing SLOTS-1 SHALL enter DRAIN.
REQ-019 DRAIN: SHALL evaluate the final word for one cycle, then return to IDLE; total fetch = SLOTS+1 cycles from line_start.
REQ-020 busy SHALL be 1 in SCAN and DRAIN, 0 in IDLE.
REQ-021 Each returned word SHALL be evaluated one cycle after its address; hit when valid=1 and y <= line_y < y+SPR_SIZE, compared at 11 bits (no wrap).
REQ-022 Hits SHALL fill entries 0..MAX_HITS-1 in ascending address order; lower address = higher draw priority.
REQ-023 A hit arriving with all entries full SHALL be dropped and SHALL set overflow, held until next line_start.
REQ-024 Each entry SHALL store id, hflip, x, row, col and v = (line_y - y)[4:0].
REQ-025 line_start during SCAN/DRAIN SHALL abort and restart the fetch per REQ-017.
REQ-026 Pixel lookup SHALL be registered: inputs sampled at cycle n, outputs valid at n+1.
REQ-027 pix_hit SHALL be 1 when video_on=1, busy=0, and some valid entry has x <= pixel_x < x+SPR_SIZE (11-bit compare).
REQ-028 With multiple matching entries, the lowest-index entry SHALL drive outputs.
REQ-029 pix_u SHALL be (pixel_x - x)[4:0], or SPR_SIZE-1 minus that when hflip=1; pix_v from entry.
REQ-030 When pix_hit=0, pix_id, pix_row, pix_col, pix_u, pix_v SHALL be 0.

Reset
REQ-031 reset SHALL force IDLE, rd_addr=0, all entries invalid, pix_hit=0, all pix_* outputs 0, busy=0, overflow=0 on the next edge.
REQ-032 reset mid-SCAN SHALL discard partial results; first post-reset line_start starts a clean fetch.
REQ-033 reset SHALL take priority over line_start in the same cycle.

Verification
REQ-034 Slot 0 = {1,id0,0,x=80,y=400,row0,col2}, others invalid; line_start line_y=410 -> busy 9 cycles, then pixel_x=85 video_on=1 -> next cycle pix_hit=1, id=0, col=2, u=5, v=10.
REQ-035 Same slot, line_y=432 and line_y=399 -> pix_hit=0 for all pixel_x.
REQ-036 Slots 0..5 all valid, y=100, x=10*i; line_y=100 -> entries hold slots 0..3, overflow=1; pixel_x=15 -> pix_id of slot 0 (priority), u=15.
REQ-037 hflip=1, x=200, pixel_x=200 -> u=31; pixel_x=231 -> u=0; pixel_x=232 -> pix_hit=0.
REQ-038 line_start at cycle 4 of a fetch -> fetch restarts, busy held 9 further cycles, entries reflect new line_y only.
REQ-039 reset asserted mid-SCAN -> next cycle busy=0, pix_hit=0, overflow=0; pixel_x inside former sprite -> pix_hit=0.
